// File: rtl/pipeline_pkg.sv
// pipeline_pkg: IF/ID payload and fetch queue entry types shared by the fetch unit.
// Also hosts the saturating increment used by the optional FETCH_PERF_CNT_EN counters.
package pipeline_pkg;
  localparam int PKG_XLEN = 32;
  typedef struct packed {
    logic [31:0]         instr;
    logic [PKG_XLEN-1:0] PC;
    logic [PKG_XLEN-1:0] PCPlus4;
  } ifid_t;
  typedef struct packed {
    logic [31:0]         instr;
    logic [PKG_XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; depth need not be a power of two.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i;
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_comb begin
    rd_d  = flush_i ? '0 : do_pop ? inc(rd_q) : rd_q;
    wr_d  = flush_i ? '0 : do_push ? inc(wr_q) : wr_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  assert property (@(posedge clk) disable iff (reset) !(do_push && !do_pop && full_o))
    else $error("fetch_fifo overflow");
  assert property (@(posedge clk) disable iff (reset) !(do_pop && empty_o))
    else $error("fetch_fifo underflow");
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing req/gnt/rvalid word fetches into a fetch queue for ID.
// Define FETCH_PERF_CNT_EN to add saturating fetched/dropped/stall counters.
module fetch_unit import pipeline_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            valid_o,
  input  logic            ready_i,
  output ifid_t           outputs,
  output logic [XLEN-1:0] PCPlus4F
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_dropped_o,
  output logic [31:0]     perf_stall_o
`endif
);
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int FCW = $clog2(FQ_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTST + 1);
  logic [XLEN-1:0] pc_q, pc_d, tag_pc;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [FCW-1:0] fq_cnt;
  logic [TCW-1:0] tag_cnt;
  logic grant, keep, stale, fq_pop, fq_full, fq_empty, tag_full, tag_empty;
  logic unused_pc_lsb;
  fetch_entry_t head;
  assign unused_pc_lsb = &{1'b0, redirect_pc_i[1:0]};
  // Credits cover both queued words and words still in flight, so a push never overflows.
  assign imem_req_o = !reset && !redirect_i && (outst_q < OW'(MAX_OUTST))
                      && (32'(fq_cnt) + 32'(outst_q) < 32'(FQ_DEPTH));
  assign imem_addr_o = pc_q;
  assign PCPlus4F = pc_q + XLEN'(4);
  assign grant = imem_req_o && imem_gnt_i;
  assign stale = imem_rvalid_i && drop_q != '0;
  assign keep = imem_rvalid_i && drop_q == '0;
  assign valid_o = !fq_empty;
  assign fq_pop = valid_o && ready_i && !redirect_i;
  assign outputs = valid_o ? ifid_t'{instr: head.instr, PC: head.pc, PCPlus4: head.pc + 32'd4} : '0;
  always_comb begin
    pc_d    = redirect_i ? {redirect_pc_i[XLEN-1:2], 2'b00} : grant ? pc_q + XLEN'(4) : pc_q;
    outst_d = outst_q + OW'(grant) - OW'(imem_rvalid_i);
    drop_d  = redirect_i ? outst_d : stale ? drop_q - OW'(1) : drop_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fq (
    .clk     (clk),
    .reset   (reset),
    .push_i  (keep),
    .pop_i   (fq_pop),
    .flush_i (redirect_i),
    .data_i  ({imem_rdata_i, tag_pc}),
    .data_o  (head),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_cnt)
  );
  // Stale tags are flushed on redirect; their responses are accounted for by drop_q instead.
  fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(XLEN)) u_tag (
    .clk     (clk),
    .reset   (reset),
    .push_i  (grant),
    .pop_i   (keep),
    .flush_i (redirect_i),
    .data_i  (pc_q),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );
  assert property (@(posedge clk) disable iff (reset) !(grant && tag_full))
    else $error("fetch_unit tag overflow");
  assert property (@(posedge clk) disable iff (reset) !(keep && tag_empty))
    else $error("fetch_unit response without tag");
  assert property (@(posedge clk) disable iff (reset) 32'(tag_cnt) <= 32'(outst_q))
    else $error("fetch_unit tag count exceeds outstanding");
  assert property (@(posedge clk) disable iff (reset) !(keep && fq_full && !fq_pop && !redirect_i))
    else $error("fetch_unit queue overflow");
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_fetched_o <= '0;
      perf_dropped_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      perf_fetched_o <= sat_inc(perf_fetched_o, keep);
      perf_dropped_o <= sat_inc(perf_dropped_o, stale);
      perf_stall_o   <= sat_inc(perf_stall_o, valid_o && !ready_i);
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic against an in-order memory and queue model.
module tb_fetch_unit;
  import pipeline_pkg::*;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int FQ_DEPTH = 4;
  localparam int MAX_OUTST = 2;
  logic clk = 0, reset = 1, redirect_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0, ready_i = 0;
  logic [31:0] redirect_pc_i = 0, imem_rdata_i = 0, imem_addr_o, PCPlus4F;
  logic imem_req_o, valid_o;
  ifid_t outputs;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_dropped_o, perf_stall_o;
`endif
  fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .valid_o(valid_o),
    .ready_i(ready_i), .outputs(outputs), .PCPlus4F(PCPlus4F)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched_o), .perf_dropped_o(perf_dropped_o), .perf_stall_o(perf_stall_o)
`endif
  );
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } inflight_t;
  inflight_t infl[$];
  logic [31:0] fq[$];
  logic [31:0] pc_m, exp_seq;
  int checks = 0, failures = 0, cyc = 0, dropped = 0, vcnt;
  bit last_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory/ID side, compare against the model, then advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit g, input int lat);
    bit rv, gr, pop;
    @(negedge clk);
    rv = infl.size() > 0 && infl[0].due <= cyc;
    redirect_i = redir; redirect_pc_i = rpc; ready_i = rdy; imem_gnt_i = g; imem_rvalid_i = rv;
    imem_rdata_i = rv ? mem_word(infl[0].addr) : 32'hDEAD_BEEF;
    #1;
    chk("req", 96'(imem_req_o), 96'(!redir && infl.size() < MAX_OUTST && fq.size() + infl.size() < FQ_DEPTH));
    if (imem_req_o) chk("addr", 96'(imem_addr_o), 96'(pc_m));
    chk("valid", 96'(valid_o), 96'(fq.size() > 0));
    chk("head", outputs, fq.size() > 0 ? {mem_word(fq[0]), fq[0], fq[0] + 32'd4} : 96'd0);
    chk("pcplus4f", 96'(PCPlus4F), 96'(pc_m + 32'd4));
    last_valid = valid_o;
    gr = imem_req_o && g;
    pop = valid_o && rdy && !redir;
    if (pop) begin
      chk("order", 96'(outputs.PC), 96'(exp_seq));
      exp_seq += 32'd4;
      void'(fq.pop_front());
    end
    if (rv) begin
      if (infl[0].stale) dropped++;
      else fq.push_back(infl[0].addr);
      void'(infl.pop_front());
    end
    if (gr) begin
      infl.push_back('{addr: pc_m, due: cyc + lat, stale: 1'b0});
      pc_m += 32'd4;
    end
    if (redir) begin
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      pc_m = {rpc[31:2], 2'b00};
      exp_seq = pc_m;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1; redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; ready_i = 0;
    #1;
    chk("rst_valid", 96'(valid_o), 96'd0);
    chk("rst_req", 96'(imem_req_o), 96'd0);
    chk("rst_out", outputs, 96'd0);
    infl.delete(); fq.delete();
    pc_m = RST_PC; exp_seq = RST_PC; dropped = 0;
    repeat (n) @(negedge clk);
    chk("rst_pc", 96'(imem_addr_o), 96'(RST_PC));
    reset = 0;
  endtask

  initial begin
    do_reset(2);
    repeat (3) step(0, 0, 1, 1, 1);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1, 1);
      vcnt += int'(last_valid);
    end
    chk("throughput", 96'(vcnt), 96'd10);
    repeat (10) step(0, 0, 0, 1, 1);
    repeat (10) step(0, 0, 1, 1, 1);
    repeat (20) step(0, 0, 1, 1, 3);
    for (int i = 0; i < 10 && infl.size() < 2; i++) step(0, 0, 1, 1, 3);
    step(1, 32'h203, 1, 1, 3);
    repeat (15) step(0, 0, 1, 1, 3);
    repeat (6) step(0, 0, 1, 1, 2);
    for (int i = 0; i < 10 && !(infl.size() > 0 && infl[0].due <= cyc); i++) step(0, 0, 1, 1, 2);
    step(1, 32'h400, 1, 1, 2);
    repeat (10) step(0, 0, 1, 1, 2);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(1, 4));
    for (int i = 0; i < 20 && fq.size() < FQ_DEPTH; i++) step(0, 0, 0, 1, 1);
    do_reset(2);
    repeat (20) step(0, 0, 1, 1, 1);
    for (int i = 0; i < 10 && infl.size() < 2; i++) step(0, 0, 1, 1, 3);
    step(1, 32'h203, 1, 1, 3);
    repeat (10) step(0, 0, 1, 1, 3);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_dropped", 96'(perf_dropped_o), 96'(dropped));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
